x25519_ladder_sequencer: RTL and testbench

//  Sequences the X25519 Montgomery ladder (NaCl mainloop) around one main-loop-iteration datapath instance.

---
 rtl/x25519_ladder_sequencer.sv | 134 +++++++++++++
 tb/tb_x25519_ladder_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x25519_ladder_sequencer.sv
// Control sequencer for the X25519 Montgomery ladder: drives one external ladder-step
// datapath through 255 constant-time iterations (scalar bit 254 down to 0).
module x25519_ladder_sequencer #(
  parameter int CLAMP        = 1,
  parameter int DRAIN_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] scalar,
  input  logic [263:0] work_low,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [511:0] xzm_out,
  output logic [511:0] xzm1_out,
  output logic         iter_en,
  output logic [511:0] iter_xzm,
  output logic [511:0] iter_xzm1,
  output logic         iter_b,
  output logic [263:0] iter_work_low,
  input  logic         iter_valid,
  input  logic [511:0] iter_xzm_in,
  input  logic [511:0] iter_xzm1_in
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   drain_cnt;
  logic [7:0]         pos;
  logic [255:0]       scalar_l;
  logic [255:0]       scalar_c;

  function automatic logic [255:0] clamp_scalar(input logic [255:0] s);
    logic [255:0] c;
    c = s;
    if (CLAMP != 0) begin
      c[2:0] = 3'b000;
      c[255] = 1'b0;
      c[254] = 1'b1;
    end
    return c;
  endfunction

  assign scalar_c = clamp_scalar(scalar);

  // iter_xzm/iter_xzm1 double as the ladder state registers, so the datapath
  // operands stay stable from the iter_en pulse until the result comes back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_DRAIN;
      drain_cnt     <= '0;
      pos           <= '0;
      scalar_l      <= '0;
      ready         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      iter_en       <= 1'b0;
      iter_b        <= 1'b0;
      xzm_out       <= '0;
      xzm1_out      <= '0;
      iter_xzm      <= '0;
      iter_xzm1     <= '0;
      iter_work_low <= '0;
    end else begin
      iter_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_DRAIN: begin
          if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        S_IDLE: begin
          // The cycle carrying done lands here with ready still low.
          if (!ready) begin
            ready <= 1'b1;
          end else if (start) begin
            scalar_l      <= scalar_c;
            iter_work_low <= work_low;
            iter_xzm      <= {256'd0, 256'd1};
            iter_xzm1     <= {256'd1, work_low[255:0]};
            pos           <= 8'd254;
            iter_b        <= scalar_c[254];
            iter_en       <= 1'b1;
            ready         <= 1'b0;
            busy          <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (iter_valid) begin
            iter_xzm  <= iter_xzm_in;
            iter_xzm1 <= iter_xzm1_in;
            if (pos == 8'd0) begin
              state <= S_FIN;
            end else begin
              pos     <= pos - 8'd1;
              iter_b  <= scalar_l[pos - 8'd1];
              iter_en <= 1'b1;
              state   <= S_ISSUE;
            end
          end
        end
        S_FIN: begin
          xzm_out  <= iter_xzm;
          xzm1_out <= iter_xzm1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_DRAIN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// Bench for x25519_ladder_sequencer: unclamped and clamped instances share one stimulus,
// each served by a mock datapath (scrambler or real field ladder step).
`timescale 1ns/1ps
module tb_x25519_ladder_sequencer;

  localparam int D = 40;
  localparam logic [255:0] P = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam logic [511:0] K = {8{64'h9e3779b97f4a7c15}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [255:0] scalar = '0;
  logic [263:0] work_low = '0;

  logic         ready[2], busy[2], done[2], iter_en[2], iter_b[2], iter_valid[2];
  logic [511:0] xzm_out[2], xzm1_out[2], iter_xzm[2], iter_xzm1[2];
  logic [263:0] iter_work_low[2];
  logic [511:0] res_m[2]  = '{512'd0, 512'd0};
  logic [511:0] res_m1[2] = '{512'd0, 512'd0};
  logic [511:0] pend_m[2]  = '{512'd0, 512'd0};
  logic [511:0] pend_m1[2] = '{512'd0, 512'd0};
  logic         mock_vld[2] = '{1'b0, 1'b0};
  logic         stray_vld = 1'b0;
  bit           stray_arm = 1'b0;
  int           cnt[2] = '{0, 0};
  int           lat = 1;
  bit           field_mode = 1'b0;

  int cyc = 0;
  int en_total[2] = '{0, 0};
  bit bq[2][$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign iter_valid[0] = mock_vld[0] | stray_vld;
  assign iter_valid[1] = mock_vld[1] | stray_vld;

  x25519_ladder_sequencer #(.CLAMP(0), .DRAIN_CYCLES(D)) dut0 (
    .clk(clk), .rst(rst), .start(start), .scalar(scalar), .work_low(work_low),
    .ready(ready[0]), .busy(busy[0]), .done(done[0]),
    .xzm_out(xzm_out[0]), .xzm1_out(xzm1_out[0]),
    .iter_en(iter_en[0]), .iter_xzm(iter_xzm[0]), .iter_xzm1(iter_xzm1[0]),
    .iter_b(iter_b[0]), .iter_work_low(iter_work_low[0]),
    .iter_valid(iter_valid[0]), .iter_xzm_in(res_m[0]), .iter_xzm1_in(res_m1[0]));

  x25519_ladder_sequencer #(.CLAMP(1), .DRAIN_CYCLES(D)) dut1 (
    .clk(clk), .rst(rst), .start(start), .scalar(scalar), .work_low(work_low),
    .ready(ready[1]), .busy(busy[1]), .done(done[1]),
    .xzm_out(xzm_out[1]), .xzm1_out(xzm1_out[1]),
    .iter_en(iter_en[1]), .iter_xzm(iter_xzm[1]), .iter_xzm1(iter_xzm1[1]),
    .iter_b(iter_b[1]), .iter_work_low(iter_work_low[1]),
    .iter_valid(iter_valid[1]), .iter_xzm_in(res_m[1]), .iter_xzm1_in(res_m1[1]));

  // ---------------- field arithmetic mod 2^255-19 ----------------
  function automatic logic [255:0] fred(input logic [511:0] t);
    logic [511:0] r;
    r = t % {256'd0, P};
    return r[255:0];
  endfunction
  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    return fred({256'd0, a} + {256'd0, b});
  endfunction
  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    return fred({256'd0, fred({256'd0, a})} + {256'd0, P} - {256'd0, fred({256'd0, b})});
  endfunction
  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    return fred({256'd0, a} * {256'd0, b});
  endfunction
  function automatic logic [255:0] finv(input logic [255:0] z);
    logic [255:0] r, e;
    r = 256'd1;
    e = P - 256'd2;
    for (int i = 254; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, z);
    end
    return r;
  endfunction

  // One NaCl mainloop step: select by b, double/add, select back.
  function automatic void ladder_step(input logic [511:0] m, input logic [511:0] m1,
                                      input logic [255:0] u, input logic b,
                                      output logic [511:0] nm, output logic [511:0] nm1);
    logic [255:0] x, z, x1, z1, a, bb, c, d, aa, b2, da, cb, e, xn, zn, xn1, zn1, t;
    x  = b ? m1[255:0]   : m[255:0];
    z  = b ? m1[511:256] : m[511:256];
    x1 = b ? m[255:0]    : m1[255:0];
    z1 = b ? m[511:256]  : m1[511:256];
    a  = fadd(x, z);   bb = fsub(x, z);
    c  = fadd(x1, z1); d  = fsub(x1, z1);
    aa = fmul(a, a);   b2 = fmul(bb, bb);
    da = fmul(c, bb);  cb = fmul(d, a);
    e  = fsub(aa, b2);
    xn = fmul(aa, b2);
    zn = fmul(e, fadd(aa, fmul(256'd121665, e)));
    t   = fadd(da, cb);
    xn1 = fmul(t, t);
    t   = fsub(da, cb);
    zn1 = fmul(fmul(t, t), u);
    nm  = b ? {zn1, xn1} : {zn, xn};
    nm1 = b ? {zn, xn} : {zn1, xn1};
  endfunction

  // Order-sensitive scrambler used as the cheap mock datapath.
  function automatic void mock_step(input logic [511:0] m, input logic [511:0] m1, input logic b,
                                    output logic [511:0] nm, output logic [511:0] nm1);
    nm  = {m[510:0], m[511]} ^ m1 ^ (b ? K : 512'd0);
    nm1 = m1 + m + {511'd0, b};
  endfunction

  function automatic void ref_run(input logic [255:0] s, input logic [263:0] u,
                                  output logic [511:0] m, output logic [511:0] m1);
    logic [511:0] a, a1;
    m  = {256'd0, 256'd1};
    m1 = {256'd1, u[255:0]};
    for (int p = 254; p >= 0; p--) begin
      mock_step(m, m1, s[p], a, a1);
      m  = a;
      m1 = a1;
    end
  endfunction

  function automatic logic [255:0] clamp_ref(input logic [255:0] s);
    logic [255:0] r;
    r = s;
    r[2:0] = 3'b000;
    r[255] = 1'b0;
    r[254] = 1'b1;
    return r;
  endfunction

  function automatic logic [255:0] brev(input logic [255:0] v);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = v[8*(31-k) +: 8];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [254:0] gather(input int i, input int base);
    logic [254:0] g;
    g = '0;
    for (int k = 0; k < 255; k++)
      if (base + k < bq[i].size()) g[254-k] = bq[i][base+k];
    return g;
  endfunction

  // ---------------- mock datapath: result valid L+1 cycles after iter_en ----------------
  always @(negedge clk) begin
    logic [511:0] nm, nm1;
    for (int i = 0; i < 2; i++) begin
      mock_vld[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i] = cnt[i] - 1;
        if (cnt[i] == 0) begin
          mock_vld[i] = 1'b1;
          res_m[i]  = pend_m[i];
          res_m1[i] = pend_m1[i];
        end
      end
      if (iter_en[i] === 1'b1) begin
        if (field_mode) ladder_step(iter_xzm[i], iter_xzm1[i], iter_work_low[i][255:0], iter_b[i], nm, nm1);
        else            mock_step(iter_xzm[i], iter_xzm1[i], iter_b[i], nm, nm1);
        pend_m[i]  = nm;
        pend_m1[i] = nm1;
        cnt[i]     = lat + 1;
      end
    end
  end

  // Spurious valid landing in every ISSUE cycle while armed.
  always @(negedge clk) stray_vld = stray_arm && (iter_en[0] === 1'b1);

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (iter_en[i] === 1'b1) begin
        en_total[i] = en_total[i] + 1;
        bq[i].push_back(iter_b[i]);
      end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [255:0] s, input logic [263:0] u, output int acc);
    scalar = s;
    work_low = u;
    start = 1'b1;
    acc = -1;
    for (int n = 0; n < 4 * D && acc < 0; n++) begin
      if (ready[0] === 1'b1) acc = cyc;
      else tick();
    end
    tick();
    start = 1'b0;
    if (acc < 0) chk("accept_timeout", 512'd0, 512'd1);
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int n = 0; n < budget && dc < 0; n++) begin
      if (done[0] === 1'b1) dc = cyc;
      else tick();
    end
    if (dc < 0) chk("done_timeout", 512'd0, 512'd1);
  endtask

  task automatic wait_en(input int target, input int budget);
    int n;
    n = 0;
    while (en_total[0] < target && n < budget) begin
      tick();
      n++;
    end
    if (en_total[0] < target) chk("iter_en_timeout", 512'(en_total[0]), 512'(target));
  endtask

  task automatic count_drain(output int n);
    n = 0;
    while (ready[0] !== 1'b1 && n < 4 * D) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [255:0] s;
    logic [263:0] u;
    int           l;
    logic [254:0] b0, b1;
    logic [511:0] m0, m10, m1, m11;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n, acc, dc, base0, base1, en_mark;
    logic [254:0] g1;
    logic [255:0] sa, sb, ta, tb, rfc_k, rfc_u, rfc_o, rx, rz;
    logic [263:0] ua, ub;
    logic [511:0] em, em1;

    for (int v = 0; v < 6; v++) begin
      vt[v].s = (v == 0) ? 256'd0 : (v == 1) ? {256{1'b1}} : rnd256();
      vt[v].u = {9'd0, rnd256() >> 1};
      vt[v].l = (v == 0) ? 7 : (v == 1) ? 3 : int'($urandom_range(4, 1));
      vt[v].b0 = vt[v].s[254:0];
      ta = clamp_ref(vt[v].s);
      vt[v].b1 = ta[254:0];
      ref_run(vt[v].s, vt[v].u, vt[v].m0, vt[v].m10);
      ref_run(ta, vt[v].u, vt[v].m1, vt[v].m11);
    end

    // Reset values, then a start pulse inside the drain window.
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), 512'(ready[i]), 512'd0);
      chk($sformatf("rst_busy%0d", i), 512'(busy[i]), 512'd0);
      chk($sformatf("rst_iter_en%0d", i), 512'(iter_en[i]), 512'd0);
      chk($sformatf("rst_xzm_out%0d", i), xzm_out[i], 512'd0);
    end
    chk("rst_done", 512'(done[0]), 512'd0);
    chk("rst_iter_xzm1", iter_xzm1[0], 512'd0);
    chk("rst_work_low", 512'(iter_work_low[0]), 512'd0);
    tick();
    tick();
    rst = 1'b0;
    scalar = rnd256();
    work_low = {8'd0, rnd256()};
    n = 0;
    while (ready[0] !== 1'b1 && n < 4 * D) begin
      tick();
      n++;
      if (n == 10) start = 1'b1;
      if (n == 11) start = 1'b0;
    end
    chk("drain_len", 512'(n), 512'(D));
    chk("drain_no_iter_en", 512'(en_total[0] + en_total[1]), 512'd0);
    chk("drain_work_low", 512'(iter_work_low[0]), 512'd0);

    // Table-driven runs against the reference ladder.
    for (int v = 0; v < 6; v++) begin
      lat = vt[v].l;
      stray_arm = (v == 2);
      base0 = en_total[0];
      base1 = en_total[1];
      launch(vt[v].s, vt[v].u, acc);
      wait_done(255 * (lat + 2) + 40, dc);
      stray_arm = 1'b0;
      chk($sformatf("v%0d_run_len", v), 512'(dc - acc), 512'(255 * (lat + 2) + 2));
      chk($sformatf("v%0d_iter_count", v), 512'(en_total[0] - base0), 512'd255);
      chk($sformatf("v%0d_bits_raw", v), 512'(gather(0, base0)), 512'(vt[v].b0));
      g1 = gather(1, base1);
      chk($sformatf("v%0d_bits_clamped", v), 512'(g1), 512'(vt[v].b1));
      chk($sformatf("v%0d_clamp_first", v), 512'(g1[254]), 512'd1);
      chk($sformatf("v%0d_clamp_last3", v), 512'(g1[2:0]), 512'd0);
      chk($sformatf("v%0d_xzm_raw", v), xzm_out[0], vt[v].m0);
      chk($sformatf("v%0d_xzm1_raw", v), xzm1_out[0], vt[v].m10);
      chk($sformatf("v%0d_xzm_clamped", v), xzm_out[1], vt[v].m1);
      chk($sformatf("v%0d_xzm1_clamped", v), xzm1_out[1], vt[v].m11);
      chk($sformatf("v%0d_busy_at_done", v), 512'(busy[0]), 512'd0);
      chk($sformatf("v%0d_ready_at_done", v), 512'(ready[0]), 512'd0);
      tick();
      chk($sformatf("v%0d_ready_after", v), 512'(ready[0]), 512'd1);
      chk($sformatf("v%0d_done_pulse", v), 512'(done[0]), 512'd0);
    end

    // start re-pulsed mid-run with new operands, then held through done.
    lat = 2;
    sa = rnd256(); ua = {9'd0, rnd256() >> 1};
    sb = rnd256(); ub = {9'd0, rnd256() >> 1};
    base0 = en_total[0];
    launch(sa, ua, acc);
    wait_en(base0 + 3, 100);
    scalar = sb; work_low = ub; start = 1'b1;
    tick();
    start = 1'b0;
    chk("repulse_work_low", 512'(iter_work_low[0]), 512'(ua));
    wait_en(base0 + 200, 1500);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_en(base0 + 255, 600);
    start = 1'b1;
    wait_done(40, dc);
    ref_run(sa, ua, em, em1);
    chk("repulse_xzm", xzm_out[0], em);
    chk("repulse_xzm1", xzm1_out[0], em1);
    chk("repulse_bits", 512'(gather(0, base0)), 512'(sa[254:0]));
    chk("repulse_count", 512'(en_total[0] - base0), 512'd255);
    tick();
    chk("held_ready", 512'(ready[0]), 512'd1);
    tick();
    chk("held_iter_en", 512'(iter_en[0]), 512'd1);
    chk("held_work_low", 512'(iter_work_low[0]), 512'(ub));
    start = 1'b0;
    wait_done(255 * (lat + 2) + 40, dc);
    ref_run(sb, ub, em, em1);
    chk("second_run_xzm", xzm_out[0], em);
    chk("second_run_bits", 512'(gather(0, base0 + 255)), 512'(sb[254:0]));

    // rst during iteration 100 with a stale result arriving 3 cycles later.
    lat = 7;
    base0 = en_total[0];
    launch(rnd256(), {9'd0, rnd256() >> 1}, acc);
    wait_en(base0 + 100, 2000);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 512'(busy[0]), 512'd0);
    chk("midrst_ready", 512'(ready[0]), 512'd0);
    chk("midrst_iter_en", 512'(iter_en[0]), 512'd0);
    chk("midrst_xzm_out", xzm_out[0], 512'd0);
    chk("midrst_iter_xzm", iter_xzm[0], 512'd0);
    chk("midrst_work_low", 512'(iter_work_low[1]), 512'd0);
    tick();
    rst = 1'b0;
    en_mark = en_total[0];
    count_drain(n);
    chk("midrst_drain_len", 512'(n), 512'(D));
    chk("midrst_no_iter_en", 512'(en_total[0] - en_mark), 512'd0);
    chk("midrst_stale_ignored", iter_xzm[0], 512'd0);
    chk("midrst_stale_ignored1", iter_xzm1[1], 512'd0);

    // Real field datapath on the RFC 7748 vector (clamped instance).
    field_mode = 1'b1;
    lat = 1;
    ta = 256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4;
    tb = 256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c;
    rfc_k = brev(ta);
    rfc_u = brev(tb);
    ta = 256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552;
    rfc_o = brev(ta);
    launch(rfc_k, {8'd0, rfc_u}, acc);
    wait_done(255 * (lat + 2) + 40, dc);
    rx = xzm_out[1][255:0];
    rz = xzm_out[1][511:256];
    chk("rfc7748_result", 512'(fmul(rx, finv(rz))), 512'(rfc_o));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
